// File: rtl/umich_op_arbiter.sv
// Round-robin arbiter that shares one pipelined ALU/compare unit among NUM_REQ requesters.
// Results leave through a single tagged response channel that can apply backpressure.
module umich_op_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clocked_on,
  input  logic                     synch_clear,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_z,
  output logic [31:0]              stall_cnt
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_LTU = 3'd3,
    OP_LTS = 3'd4, OP_EQ  = 3'd5, OP_SHL = 3'd6, OP_XOR = 3'd7
  } op_e;

  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_LTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LTS: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:  r = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SHL: r = (b >= WIDTH'(WIDTH)) ? '0 : (a << b);
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                 vld_q [LATENCY];
  logic                 vld_d [LATENCY];
  logic [ID_W-1:0]      id_q  [LATENCY];
  logic [ID_W-1:0]      id_d  [LATENCY];
  logic [WIDTH-1:0]     z_q   [LATENCY];
  logic [WIDTH-1:0]     z_d   [LATENCY];
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic                 stall;
  logic                 issue;
  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_idx;
  int                   gnt_sel;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // Handshakes: a request transfers when req_valid[i] & req_ready[i]; a response
  // transfers when rsp_valid & rsp_ready. A pending response with rsp_ready low
  // freezes every stage and withholds all grants.
  always_comb begin
    stall     = vld_q[LATENCY-1] & ~rsp_ready;
    issue     = ~stall & gnt_found;
    gnt_sel   = int'(gnt_idx);
    req_ready = '0;
    if (issue) req_ready[gnt_idx] = 1'b1;
    ptr_d = issue ? gnt_idx : ptr_q;

    for (int s = 0; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s];
      id_d[s]  = id_q[s];
      z_d[s]   = z_q[s];
    end
    if (!stall) begin
      vld_d[0] = issue;
      id_d[0]  = issue ? gnt_idx : '0;
      z_d[0]   = issue ? alu(req_op[3*gnt_sel +: 3],
                             req_a[WIDTH*gnt_sel +: WIDTH],
                             req_b[WIDTH*gnt_sel +: WIDTH]) : '0;
      for (int s = 1; s < LATENCY; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
        z_d[s]   = z_q[s-1];
      end
    end

    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clocked_on) begin
    if (synch_clear) begin
      for (int s = 0; s < LATENCY; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
        z_q[s]   <= '0;
      end
      ptr_q       <= PTR_RST;
      stall_cnt_q <= '0;
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        vld_q[s] <= vld_d[s];
        id_q[s]  <= id_d[s];
        z_q[s]   <= z_d[s];
      end
      ptr_q       <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_id    = id_q[LATENCY-1];
  assign rsp_z     = z_q[LATENCY-1];
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_umich_op_arbiter.sv
// Bench for umich_op_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an in-flight-list model.
module tb_umich_op_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int L = 2;

  logic           clk;
  logic           synch_clear;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_z;
  logic [31:0]    stall_cnt;

  umich_op_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clocked_on (clk),
    .synch_clear(synch_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           id;
    logic [W-1:0] z;
    int           age;
  } ent_t;

  ent_t         fl[$];
  int           m_ptr;
  logic [31:0]  m_stall;
  bit           model_on = 1'b0;
  logic [N-1:0] hs_seen = '0;
  logic [N-1:0] prev_pend = '0;
  logic [3*N-1:0] prev_op;
  logic [W*N-1:0] prev_a, prev_b;

  function automatic logic [63:0] model_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return 64'(a < b);
      3'd4: return 64'($signed(a) < $signed(b));
      3'd5: return 64'(a == b);
      3'd6: return (b >= 64) ? 64'd0 : (a << b[5:0]);
      default: return a ^ b;
    endcase
  endfunction

  function automatic int model_grant(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    fl.delete();
    m_ptr   = N - 1;
    m_stall = '0;
  endtask

  // Single compare process: checks outputs, then advances the model across the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        bit           exp_v, exp_st;
        int           g;
        logic [N-1:0] exp_rdy;
        exp_v = (fl.size() > 0) && (fl[0].age == L - 1);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
          chk("rsp_id", rsp_id, fl[0].id);
          chk("rsp_z", rsp_z, fl[0].z);
        end
        exp_st  = exp_v && !rsp_ready;
        g       = exp_st ? -1 : model_grant(m_ptr, req_valid);
        exp_rdy = (g < 0) ? '0 : (N'(1) << g);
        chk("req_ready", req_ready, exp_rdy);
        chk("stall_cnt", stall_cnt, m_stall);
        for (int i = 0; i < N; i++) begin
          if (prev_pend[i]) begin
            chk("req_hold_valid", req_valid[i], 1'b1);
            chk("req_hold_data", {req_op[3*i +: 3], req_a[W*i +: W], req_b[W*i +: W]} ==
                                 {prev_op[3*i +: 3], prev_a[W*i +: W], prev_b[W*i +: W]}, 1'b1);
          end
        end
        if (!synch_clear) begin
          if (!exp_st) begin
            if (exp_v) void'(fl.pop_front());
            foreach (fl[k]) fl[k].age++;
            if (g >= 0) begin
              fl.push_back('{g, model_op(req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W]), 0});
              m_ptr = g;
            end
          end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
          end
        end
      end
      hs_seen   = req_valid & req_ready;
      prev_pend = req_valid & ~req_ready;
      prev_op   = req_op;
      prev_a    = req_a;
      prev_b    = req_b;
      if (synch_clear) begin
        model_reset();
        model_on = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
    req_valid[i]       = 1'b1;
    req_op[3*i +: 3]   = op;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 synch_clear = 1'b1;
    @(posedge clk); #1 synch_clear = 1'b0;
  endtask

  // Call between a negedge and the following posedge; drops each valid once granted.
  task automatic finish_pending();
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~hs_seen;
      if (req_valid == '0) break;
    end
    chk("drain_req_valid", req_valid, '0);
  endtask

  task automatic issue_one(input int r, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp, input string name);
    bit got;
    @(posedge clk); #1 set_req(r, op, a, b);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin got = 1'b1; break; end
    end
    chk({name, "_grant"}, got, 1'b1);
    @(posedge clk); #1 req_valid[r] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk({name, "_rsp"}, got, 1'b1);
    chk({name, "_z"}, rsp_z, exp);
    chk({name, "_id"}, rsp_id, 64'(r));
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 70));
      1: return '1;
      2: return {$urandom, $urandom};
      default: return 64'd1 << $urandom_range(0, 63);
    endcase
  endfunction

  task automatic run_random(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      synch_clear = ($urandom_range(0, 249) == 0);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs_seen[i]) begin
          if ($urandom_range(0, 9) < 6) set_req(i, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
          else req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    bit got;
    int hs_cnt;
    synch_clear = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 synch_clear = 1'b0;

    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single ADD from requester 2.
    @(posedge clk); #1 set_req(2, 3'd0, 64'd5, 64'd7);
    @(negedge clk); chk("t2_ready", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk); chk("t2_not_yet", rsp_valid, 1'b0);
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_id", rsp_id, 2);
    chk("t2_rsp_z", rsp_z, 12);

    // Opcode sweep.
    issue_one(1, 3'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "sub");
    issue_one(0, 3'd2, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, "mul");
    issue_one(3, 3'd3, 64'd1, '1, 64'd1, "ltu");
    issue_one(2, 3'd4, 64'd1, '1, 64'd0, "lts");
    issue_one(0, 3'd5, 64'd9, 64'd9, 64'd1, "eq");
    issue_one(1, 3'd6, 64'd1, 64'd63, 64'h8000_0000_0000_0000, "shl63");
    issue_one(2, 3'd6, 64'd1, 64'd64, 64'd0, "shl64");
    issue_one(3, 3'd7, 64'hF0F0, 64'h0FF0, 64'hFF00, "xor");

    // All requesters valid continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd7, 64'(i + 1), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rr_ready", req_ready, (c < 8) ? (64'd1 << (c % 4)) : 64'd0);
      chk("rr_rsp_valid", rsp_valid, c >= 2);
      if (c >= 2) chk("rr_rsp_id", rsp_id, 64'((c - 2) % 4));
      @(posedge clk); #1;
      if (c >= 4) req_valid = req_valid & ~hs_seen;
    end

    // Backpressure with two ops in flight.
    do_reset();
    set_req(0, 3'd0, 64'd10, 64'd20);
    set_req(1, 3'd1, 64'd100, 64'd1);
    rsp_ready = 1'b0;
    @(negedge clk); chk("bp_ready0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk); chk("bp_ready1", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0; set_req(2, 3'd0, 64'd1, 64'd1);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_z", rsp_z, 30);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_stall_cnt", stall_cnt, 64'(c - 2));
      @(posedge clk); #1;
      if (c == 6) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("bp_stall_total", stall_cnt, 5);
    chk("bp_first_id", rsp_id, 0);
    chk("bp_first_z", rsp_z, 30);
    chk("bp_late_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", rsp_valid, 1'b1);
    chk("bp_second_id", rsp_id, 1);
    chk("bp_second_z", rsp_z, 99);
    @(negedge clk);
    chk("bp_third_id", rsp_id, 2);
    chk("bp_third_z", rsp_z, 2);

    // Reset with ops in flight.
    @(posedge clk); #1 set_req(1, 3'd0, 64'd3, 64'd4); set_req(2, 3'd0, 64'd5, 64'd6);
    @(negedge clk); chk("mr_ready1", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0; synch_clear = 1'b1;
    @(negedge clk); chk("mr_ready2", req_ready, 4'b0100);
    @(posedge clk); #1 synch_clear = 1'b0; req_valid[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mr_no_rsp", seen, 1'b0);
    @(posedge clk); #1 set_req(0, 3'd0, 64'd1, 64'd2); set_req(3, 3'd0, 64'd3, 64'd4);
    @(negedge clk); chk("mr_first_grant", req_ready, 4'b0001);
    finish_pending();

    // Requester 1 must not starve behind a persistent requester 0.
    do_reset();
    set_req(0, 3'd0, 64'd7, 64'd8);
    set_req(1, 3'd0, 64'd9, 64'd10);
    hs_cnt = 0;
    got    = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      if (req_ready != '0) hs_cnt++;
      if (req_ready[1]) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("sv_granted", got, 1'b1);
    chk("sv_within_n", hs_cnt <= N, 1'b1);
    chk("sv_hs_count", hs_cnt, 2);
    finish_pending();

    // Randomized traffic.
    run_random(3000);
    synch_clear = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge clk);
    finish_pending();
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
